// File: rtl/param_concat_pkg.sv
// rtl/param_concat_pkg.sv - packing modes and width helpers for param_concat_fifo
package param_concat_pkg;

  typedef enum logic [1:0] {
    MODE_CAT    = 2'd0,
    MODE_LOHALF = 2'd1,
    MODE_SWAP   = 2'd2,
    MODE_SUM    = 2'd3
  } mode_e;

  function automatic int total_w(input int n, input int m);
    return n + m;
  endfunction

  function automatic int half_w(input int m);
    return m / 2;
  endfunction

endpackage

// File: rtl/concat_sync_fifo.sv
// rtl/concat_sync_fifo.sv - single-clock storage FIFO with wrap-around pointers
module concat_sync_fifo #(
  parameter  int W     = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push_en;
  logic          pop_en;

  // flush dominates so a cycle with flush leaves nothing behind
  assign push_en = push && !flush && !full;
  assign pop_en  = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_en) wptr <= wptr + AW'(1);
      if (pop_en)  rptr <= rptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/param_concat_fifo.sv
// rtl/param_concat_fifo.sv - packs operands a/b per mode and queues them in a FIFO
module param_concat_fifo
  import param_concat_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int M     = 8,
  parameter  int DEPTH = 4,
  localparam int TOTAL = total_w(N, M),
  localparam int HALF  = half_w(M),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TOTAL-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic             alive;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [TOTAL-1:0] packed_word;

  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign in_ready  = alive && !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      drop <= 1'b0;
    else if (in_valid && !in_ready)  drop <= 1'b1;
  end

  always_comb begin
    packed_word = '0;
    case (mode_e'(mode))
      MODE_CAT:    packed_word = {a, b};
      MODE_LOHALF: packed_word = {a, {HALF{1'b0}}, b[HALF-1:0]};
      MODE_SWAP:   packed_word = {b, a};
      MODE_SUM:    packed_word = {{M{1'b0}}, a} + {{N{1'b0}}, b};
      default:     packed_word = '0;
    endcase
  end

  concat_sync_fifo #(
    .W     (TOTAL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (packed_word),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_param_concat_fifo.sv
// tb/tb_param_concat_fifo.sv - randomized bench with queue reference model for param_concat_fifo
module tb_param_concat_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  a = '0;
  logic [7:0]  b = '0;
  logic [1:0]  mode = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [2:0]  count;
  logic        drop;

  int passed = 0;
  int total  = 0;

  logic [11:0] mq[$];
  bit          m_alive = 1'b0;
  bit          m_drop  = 1'b0;

  param_concat_fifo #(.N(4), .M(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] pack(input logic [3:0] aa, input logic [7:0] bb, input logic [1:0] md);
    int r;
    case (md)
      2'd0:    r = aa * 256 + bb;
      2'd1:    r = aa * 256 + (bb % 16);
      2'd2:    r = bb * 16 + aa;
      default: r = aa + bb;
    endcase
    return r[11:0];
  endfunction

  function automatic bit m_ready();
    return m_alive && (mq.size() < 4) && !flush;
  endfunction

  // reference model: a queue of packed words
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_alive = 1'b0;
      m_drop  = 1'b0;
    end else begin
      bit rdy;
      logic [11:0] w;
      rdy = m_ready();
      w   = pack(a, b, mode);
      if (in_valid && !rdy) m_drop = 1'b1;
      if (flush) mq.delete();
      else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back(w);
      end
      m_alive = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("drop", 32'(drop), 32'(m_drop));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
  end

  task automatic drv(input bit v, input logic [3:0] aa, input logic [7:0] bb,
                     input logic [1:0] md, input bit fl, input bit ordy);
    in_valid  = v;
    a         = aa;
    b         = bb;
    mode      = md;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) drv(1'b0, 4'h0, 8'h00, 2'd0, 1'b0, ordy);
  endtask

  logic [11:0] lit4 [4];

  initial begin
    lit4[0] = 12'hA5C; lit4[1] = 12'hA0C; lit4[2] = 12'h5CA; lit4[3] = 12'h066;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1, 1'b0);
    chk("ready_after_release", 32'(in_ready), 32'd1);

    // four packing modes on the same operands
    for (int i = 0; i < 4; i++) drv(1'b1, 4'hA, 8'h5C, 2'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("model_pack", 32'(mq[i]), 32'(lit4[i]));
    for (int i = 0; i < 4; i++) begin
      chk("mode_out", 32'(out_data), 32'(lit4[i]));
      idle(1, 1'b1);
    end

    // overflow with consumer stalled
    for (int i = 0; i < 4; i++) drv(1'b1, 4'(i), 8'(i * 3), 2'd0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drv(1'b1, 4'hF, 8'hEE, 2'd0, 1'b0, 1'b0);
    chk("overflow_count", 32'(count), 32'd4);
    chk("overflow_drop", 32'(drop), 32'd1);
    idle(4, 1'b1);

    // steady push+pop at count 2 across the pointer wrap
    for (int i = 0; i < 2; i++) drv(1'b1, 4'(i + 1), 8'($urandom), 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 4'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b1);
      chk("stream_count", 32'(count), 32'd2);
    end
    idle(2, 1'b1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drv(1'b1, 4'h3, 8'(i), 2'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1, 1'b0);
    drv(1'b1, 4'h7, 8'h21, 2'd0, 1'b0, 1'b0);
    chk("post_reset_count", 32'(count), 32'd1);
    chk("post_reset_data", 32'(out_data), 32'h721);
    chk("post_reset_drop", 32'(drop), 32'd0);
    idle(1, 1'b1);

    // flush at count 3 with a word offered
    for (int i = 0; i < 3; i++) drv(1'b1, 4'h1, 8'(i), 2'd0, 1'b0, 1'b0);
    drv(1'b1, 4'h9, 8'h99, 2'd0, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_drop", 32'(drop), 32'd1);

    // sum mode carry into the upper nibble
    chk("model_sum", 32'(pack(4'hF, 8'hFF, 2'd3)), 32'h10E);
    drv(1'b1, 4'hF, 8'hFF, 2'd3, 1'b0, 1'b0);
    chk("sum_out", 32'(out_data), 32'h10E);
    idle(1, 1'b1);

    for (int i = 0; i < 400; i++)
      drv(1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom), 2'($urandom),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    idle(6, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_concat_fifo.md
PARAM_CONCAT_FIFO -- requirements
Module: param_concat_fifo

Interface
REQ-001 Parameter N, default 4: width of operand a; SHALL be >= 1.
REQ-002 Parameter M, default 8: width of operand b; SHALL be even and >= 2.
REQ-003 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of two and >= 2.
REQ-004 Derived constants: TOTAL = N+M; HALF = M/2; CW = clog2(DEPTH)+1.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input word present.
REQ-008 in_ready  out  1  FIFO can accept a word.
REQ-009 a  in  N  operand a.
REQ-010 b  in  M  operand b.
REQ-011 mode  in  2  packing mode, sampled with the word.
REQ-012 flush  in  1  synchronous clear of all stored words.
REQ-013 out_valid  out  1  head word present.
REQ-014 out_ready  in  1  consumer accepts the head word.
REQ-015 out_data  out  TOTAL  head word.
REQ-016 count  out  CW  stored entries, 0..DEPTH.
REQ-017 drop  out  1  sticky: in_valid was high while in_ready was low.

Function
REQ-018 Push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 Packing at push:
- mode 0: {a,b}
- mode 1: {a, HALF zeros, b[HALF-1:0]}
- mode 2: {b,a}
- mode 3: zero-extended a + zero-extended b in TOTAL bits; no carry loss.
REQ-020 in_ready = (count != DEPTH) && !flush.
REQ-021 out_valid = (count != 0); out_data is the oldest entry, driven from storage with no input-to-output combinational path.
REQ-022 Latency: a word pushed into an empty FIFO at edge k SHALL appear with out_valid high after edge k; no same-cycle bypass.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count unchanged; order preserved.
REQ-024 When full: in_ready low; a pop in that cycle does not enable a same-cycle push.
REQ-025 Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-026 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 flush high at an edge: count=0, pointers=0, out_valid low after the edge; push and pop are ignored that cycle; drop is unchanged.
REQ-028 drop sets on the first edge where in_valid && !in_ready, including during flush; it clears only on reset.
REQ-029 mode values apply per word; a change of mode does not affect stored entries.

Reset
REQ-030 While rst_n is low, regardless of clk: count=0, pointers=0, out_valid=0, in_ready=0, drop=0.
REQ-031 On the first edge after rst_n rises, in_ready=1.
REQ-032 Assertion of reset mid-transfer discards all stored words; storage contents need not be cleared.

Structure
REQ-033 Package param_concat_pkg SHALL hold the mode enumeration (MODE_CAT, MODE_LOHALF, MODE_SWAP, MODE_SUM) and the TOTAL/HALF helper functions.
REQ-034 Storage and pointers SHALL be in the sub-module concat_sync_fifo, parametrised by width TOTAL and depth DEPTH; packing logic SHALL stay in the top level.

Verification (N=4, M=8, DEPTH=4)
REQ-035 a=4'hA, b=8'h5C, push with modes 0, 1, 2, 3 in turn -> out_data 12'hA5C, 12'hA0C, 12'h5CA, 12'h066 in that order.
REQ-036 out_ready=0 with five consecutive pushes -> count reaches 4; in_ready low after the 4th push; 5th word not stored; drop=1.
REQ-037 At count=2, push and pop in the same cycle for 6 cycles -> count stays 2; output order matches input order across the pointer wrap.
REQ-038 At count=3, assert flush together with in_valid -> count=0, out_valid=0 after the edge; the flushed-cycle word is absent; drop=1.
REQ-039 Drop rst_n low mid-stream, asynchronously between edges -> out_valid, in_ready and count go to 0 immediately; after release the first push returns the new word only.
REQ-040 a=4'hF, b=8'hFF, mode 3 -> out_data 12'h10E.
